// File: rtl/uart_tx_framer_if.sv
// Valid/ready word handshake between upstream logic and uart_tx_framer.
// master = word producer, slave = framer.
interface uart_tx_framer_if #(
    parameter int unsigned DATA_BITS = 5
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmitter: frames parallel words as start / MSB-first data / stop bits on tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_framer #(
    parameter int unsigned DATA_BITS    = 5,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_framer_if.slave        tx_if,
    output logic                   tx_o,
    output logic                   busy_o
);

    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned DCNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [DCNT_W-1:0]    data_cnt_q, data_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 bit_done;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            data_cnt_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            data_cnt_q <= data_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bit_done = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state logic; tx_d always carries the level of the bit that starts next cycle.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        data_cnt_d = data_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != IDLE) begin
            clk_cnt_d = bit_done ? '0 : clk_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                clk_cnt_d = '0;
                if (tx_if.tx_valid) begin
                    shift_d = tx_if.tx_data;
                    state_d = START;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_if.tx_data;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_d    = DATA;
                    data_cnt_d = '0;
                    tx_d       = shift_q[DATA_BITS-1];
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d    = {shift_q[DATA_BITS-2:0], 1'b1};
                    data_cnt_d = data_cnt_q + DCNT_W'(1);
                    if (data_cnt_q == DCNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[DATA_BITS-2];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_if.tx_ready = (state_q == IDLE);
    assign tx_o           = tx_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: table-driven frames checked by a
// cycle-exact line monitor against a scoreboard, plus corner-case sequences.
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int D  = 5;
    localparam int C  = 4;
    localparam int FW = D + 2 + PAR;
    localparam int FL = FW * C;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx_o, busy_o, tx1, busy1;

    uart_tx_framer_if #(.DATA_BITS(D)) bus ();
    uart_tx_framer_if #(.DATA_BITS(D)) bus1 ();

    uart_tx_framer #(.DATA_BITS(D), .CLKS_PER_BIT(C)) dut (
        .clk    (clk),
        .rst    (rst),
        .tx_if  (bus),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

    uart_tx_framer #(.DATA_BITS(D), .CLKS_PER_BIT(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .tx_if  (bus1),
        .tx_o   (tx1),
        .busy_o (busy1)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;
    int unsigned acc_cyc  = 0;
    logic [7:0]  sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0] data;
        logic [6:0] f7;   // start, data MSB-first, stop; first-sent bit at [6]
        logic       par;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] exp_frame(input logic [6:0] f7, input logic par);
        if (PAR != 0) return {f7[6:1], par, 1'b1};
        return {1'b0, f7};
    endfunction

    // Line monitor: every bit must hold C cycles, busy high throughout, one idle cycle after.
    bit         m_act  = 1'b0;
    bit         m_idle = 1'b0;
    int         m_bit, m_cyc;
    logic       m_cur;
    logic [7:0] m_frame;

    always @(negedge clk) begin
        if (!rst) begin
            m_act  = 1'b0;
            m_idle = 1'b0;
        end else begin
            if (m_idle) begin
                chk("idle_tx", 32'(tx_o), 32'(1));
                chk("idle_busy", 32'(busy_o), 32'(0));
                chk("idle_ready", 32'(bus.tx_ready), 32'(1));
                m_idle = 1'b0;
            end
            if (!m_act && tx_o == 1'b0) begin
                m_act   = 1'b1;
                m_bit   = 0;
                m_cyc   = 0;
                m_frame = 8'h00;
            end
            if (m_act) begin
                chk("busy_in_frame", 32'(busy_o), 32'(1));
                chk("ready_in_frame", 32'(bus.tx_ready), 32'(0));
                if (m_cyc == 0) begin
                    m_cur   = tx_o;
                    m_frame = {m_frame[6:0], tx_o};
                end else begin
                    chk("bit_hold", 32'(tx_o), 32'(m_cur));
                end
                m_cyc++;
                if (m_cyc == C) begin
                    m_cyc = 0;
                    m_bit++;
                    if (m_bit == FW) begin
                        m_act  = 1'b0;
                        m_idle = 1'b1;
                        chk("frame_was_expected", 32'(sb.size() != 0), 32'(1));
                        if (sb.size() != 0) chk("frame", 32'(m_frame), 32'(sb.pop_front()));
                    end
                end
            end
        end
    end

    task automatic send(input logic [4:0] d, input logic [7:0] f, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < 200), 32'(1));
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(posedge clk);
        sb.push_back(f);
        #1;
        acc_cyc     = cyc;
        bus.tx_data = ~d;
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned a0;
        logic [7:0]  fr;

        vecs[0] = '{5'b10110, 7'b0101101, 1'b1};
        vecs[1] = '{5'b00001, 7'b0000011, 1'b1};
        vecs[2] = '{5'b11111, 7'b0111111, 1'b1};
        vecs[3] = '{5'b01010, 7'b0010101, 1'b0};
        vecs[4] = '{5'b00000, 7'b0000001, 1'b0};
        vecs[5] = '{5'b10000, 7'b0100001, 1'b1};

        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus1.tx_valid = 1'b0;
        bus1.tx_data  = '0;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'(1));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_ready", 32'(bus.tx_ready), 32'(1));
        #2 rst = 1'b1;

        // Quiet idle line.
        repeat (20) begin
            @(negedge clk);
            chk("quiet_tx", 32'(tx_o), 32'(1));
            chk("quiet_busy", 32'(busy_o), 32'(0));
            chk("quiet_ready", 32'(bus.tx_ready), 32'(1));
        end

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, exp_frame(vecs[i].f7, vecs[i].par), 1'b0);
            drain();
        end

        // Back-to-back with tx_valid held high.
        send(5'b00001, exp_frame(7'b0000011, 1'b1), 1'b1);
        a0 = acc_cyc;
        send(5'b11111, exp_frame(7'b0111111, 1'b1), 1'b0);
        chk("b2b_period", acc_cyc - a0, 32'(FL + 1));
        drain();

        // Valid pulse during DATA is ignored.
        send(5'b10110, exp_frame(7'b0101101, 1'b1), 1'b0);
        repeat (2 * C) @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 5'b00000;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        drain();
        repeat (20) begin
            @(negedge clk);
            chk("no_second_frame", 32'(busy_o), 32'(0));
        end

        // Asynchronous reset mid-DATA, then a clean frame.
        send(5'b10110, exp_frame(7'b0101101, 1'b1), 1'b0);
        repeat (2 * C + 2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx_o), 32'(1));
        chk("async_rst_busy", 32'(busy_o), 32'(0));
        chk("async_rst_ready", 32'(bus.tx_ready), 32'(1));
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        send(5'b01010, exp_frame(7'b0010101, 1'b0), 1'b0);
        drain();

        // One-cycle bits on the CLKS_PER_BIT=1 instance.
        @(negedge clk);
        bus1.tx_valid = 1'b1;
        bus1.tx_data  = 5'b10110;
        @(posedge clk);
        #1;
        bus1.tx_valid = 1'b0;
        bus1.tx_data  = 5'b00000;
        fr = 8'h00;
        for (int b = 0; b < FW; b++) begin
            @(negedge clk);
            fr = {fr[6:0], tx1};
            chk("c1_busy", 32'(busy1), 32'(1));
        end
        @(negedge clk);
        chk("c1_frame", 32'(fr), 32'(exp_frame(7'b0101101, 1'b1)));
        chk("c1_idle_busy", 32'(busy1), 32'(0));
        chk("c1_idle_tx", 32'(tx1), 32'(1));
        chk("c1_idle_ready", 32'(bus1.tx_ready), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
